// File: rtl/grad_read_arbiter.sv
// rtl/grad_read_arbiter.sv - round-robin read arbiter with burst lock for a shared gradient BRAM port
module grad_read_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic                          bram_en,
    input  logic [DATA_WIDTH-1:0]         bram_dout,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    // One tag stage per BRAM cycle plus the address register stage.
    localparam int DEPTH = READ_LATENCY + 1;

    logic [ID_W-1:0]       last_grant_q;
    logic [ID_W-1:0]       grant_id_q;
    logic                  prev_accept_q;
    logic [ADDR_WIDTH-1:0] bram_addr_q;
    logic                  bram_en_q;
    logic [DEPTH-1:0]      tag_vld_q;
    logic [DEPTH-1:0]      tag_vld_d;
    logic [ID_W-1:0]       tag_id_q [DEPTH];
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  busy_q;

    logic [ID_W-1:0]       winner_id;
    logic                  found;
    logic                  lock_hold;
    logic                  accept;
    logic [ID_W-1:0]       cand;
    int                    cand_i;

    // Winner selection: a lock re-grants the holder only while it keeps
    // requesting right after its own accept; otherwise strict rotation.
    always_comb begin
        winner_id = last_grant_q;
        found     = 1'b0;
        cand_i    = 0;
        cand      = '0;
        lock_hold = prev_accept_q & req_valid[last_grant_q] & req_lock[last_grant_q];
        if (lock_hold) begin
            found = 1'b1;
        end else begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                cand_i = (int'(last_grant_q) + off) % NUM_REQ;
                cand   = cand_i[ID_W-1:0];
                if (!found && req_valid[cand]) begin
                    found     = 1'b1;
                    winner_id = cand;
                end
            end
        end
    end

    // Grant is suppressed while reset is asserted so every output reads 0.
    always_comb begin
        accept    = found & ~rst_in;
        req_ready = '0;
        if (accept) begin
            req_ready[winner_id] = 1'b1;
        end
    end

    // Grant history and the registered BRAM address/enable.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_grant_q  <= ID_W'(NUM_REQ - 1);
            grant_id_q    <= '0;
            prev_accept_q <= 1'b0;
            bram_addr_q   <= '0;
            bram_en_q     <= 1'b0;
        end else begin
            prev_accept_q <= accept;
            bram_en_q     <= accept;
            if (accept) begin
                last_grant_q <= winner_id;
                grant_id_q   <= winner_id;
                bram_addr_q  <= req_addr[winner_id*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Next tag-valid vector; a null tag enters whenever nothing is accepted.
    always_comb begin
        tag_vld_d = {tag_vld_q[DEPTH-2:0], accept};
    end

    // Tag shift register tracking which requester owns each in-flight read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tag_vld_q <= '0;
            busy_q    <= 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_vld_q   <= tag_vld_d;
            busy_q      <= |tag_vld_d;
            tag_id_q[0] <= winner_id;
            for (int s = 1; s < DEPTH; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    // Response stage: the exiting tag steers a one-cycle pulse with the BRAM data.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= '0;
            rsp_data_q  <= bram_dout;
            if (tag_vld_q[DEPTH-1]) begin
                rsp_valid_q[tag_id_q[DEPTH-1]] <= 1'b1;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign bram_addr = bram_addr_q;
    assign bram_en   = bram_en_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

endmodule
